// File: rtl/bsg_dmc_ui_responder.sv
// Memory-side responder for the DDR UI command/write-data/read-data protocol,
// backed by a byte-lane-sliced store so masked writes touch only enabled lanes.
package bsg_dmc_ui_responder_pkg;
  typedef enum logic [2:0] {
    e_wr  = 3'd0,
    e_rd  = 3'd1,
    e_wap = 3'd2,
    e_rap = 3'd3
  } app_cmd_e;
endpackage

// One byte column of the store: synchronous write, combinational read.
module bsg_dmc_ui_responder_lane #(
  parameter int els_lg_p = 8
) (
  input  logic                clk_i,
  input  logic                w_v_i,
  input  logic [els_lg_p-1:0] w_addr_i,
  input  logic [7:0]          w_data_i,
  input  logic [els_lg_p-1:0] r_addr_i,
  output logic [7:0]          r_data_o
);
  logic [7:0] mem_r [2**els_lg_p];

  always_ff @(posedge clk_i)
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;

  assign r_data_o = mem_r[r_addr_i];
endmodule

module bsg_dmc_ui_responder
  import bsg_dmc_ui_responder_pkg::*;
#(
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 32,
  parameter int ui_burst_len_p  = 2,
  parameter int mem_els_lg_p    = 8,
  parameter int rd_latency_p    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [ui_addr_width_p-1:0]   app_addr_i,
  input  app_cmd_e                     app_cmd_i,
  input  logic                         app_en_i,
  output logic                         app_rdy_o,
  input  logic                         app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0]   app_wdf_data_i,
  input  logic [ui_data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                         app_wdf_end_i,
  output logic                         app_wdf_rdy_o,
  output logic                         app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]   app_rd_data_o,
  output logic                         app_rd_data_end_o,
  output logic                         error_o,
  output logic [15:0]                  wr_cnt_o,
  output logic [15:0]                  rd_cnt_o
);
  localparam int lanes_lp = ui_data_width_p / 8;
  localparam int beat_w_lp = (ui_burst_len_p > 1) ? $clog2(ui_burst_len_p) : 1;
  localparam int lat_w_lp  = (rd_latency_p > 1) ? $clog2(rd_latency_p) : 1;
  localparam logic [beat_w_lp-1:0] beat_last_lp = beat_w_lp'(ui_burst_len_p - 1);
  localparam logic [lat_w_lp-1:0]  lat_last_lp  = lat_w_lp'((rd_latency_p > 0) ? rd_latency_p - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, RD_DATA} state_e;

  state_e                  state_r;
  logic [mem_els_lg_p-1:0] base_r;
  logic [beat_w_lp-1:0]    beat_r;
  logic [lat_w_lp-1:0]     lat_r;

  logic                            last_beat;
  logic                            wr_v;
  logic [mem_els_lg_p-1:0]         cur_addr;
  logic [lanes_lp-1:0][7:0]        rd_lanes;
  logic [lanes_lp-1:0][7:0]        wr_lanes;
  logic                            addr_unused;

  // Upper address bits fall outside the store and are intentionally dropped.
  assign addr_unused = ^app_addr_i;

  // Ready strobes come straight off the state flop so they rise the first cycle out of reset.
  assign app_rdy_o     = (state_r == IDLE)  & ~reset_i;
  assign app_wdf_rdy_o = (state_r == WRITE) & ~reset_i;

  assign last_beat = (beat_r == beat_last_lp);
  assign wr_v      = app_wdf_wren_i & app_wdf_rdy_o;
  assign cur_addr  = base_r + mem_els_lg_p'(beat_r);
  assign wr_lanes  = app_wdf_data_i;

  for (genvar i = 0; i < lanes_lp; i++) begin : g_lane
    bsg_dmc_ui_responder_lane #(.els_lg_p(mem_els_lg_p)) lane (
      .clk_i    (clk_i),
      .w_v_i    (wr_v & ~app_wdf_mask_i[i]),
      .w_addr_i (cur_addr),
      .w_data_i (wr_lanes[i]),
      .r_addr_i (cur_addr),
      .r_data_o (rd_lanes[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r             <= IDLE;
      base_r              <= '0;
      beat_r              <= '0;
      lat_r               <= '0;
      app_rd_data_valid_o <= 1'b0;
      app_rd_data_o       <= '0;
      app_rd_data_end_o   <= 1'b0;
      error_o             <= 1'b0;
      wr_cnt_o            <= '0;
      rd_cnt_o            <= '0;
    end else begin
      app_rd_data_valid_o <= 1'b0;
      app_rd_data_o       <= '0;
      app_rd_data_end_o   <= 1'b0;

      // Write data offered while no write burst is open is dropped and flagged.
      if (app_wdf_wren_i && !app_wdf_rdy_o) error_o <= 1'b1;

      case (state_r)
        IDLE: if (app_en_i) begin
          base_r <= app_addr_i[mem_els_lg_p-1:0];
          beat_r <= '0;
          lat_r  <= '0;
          case (app_cmd_i)
            e_wr, e_wap: state_r <= WRITE;
            e_rd, e_rap: state_r <= (rd_latency_p == 0) ? RD_DATA : RD_WAIT;
            default:     state_r <= IDLE;
          endcase
        end
        WRITE: if (app_wdf_wren_i) begin
          if (app_wdf_end_i != last_beat) error_o <= 1'b1;
          if (last_beat) begin
            state_r  <= IDLE;
            wr_cnt_o <= wr_cnt_o + 16'd1;
          end else begin
            beat_r <= beat_r + 1'b1;
          end
        end
        RD_WAIT: begin
          if (lat_r == lat_last_lp) state_r <= RD_DATA;
          else                      lat_r   <= lat_r + 1'b1;
        end
        RD_DATA: begin
          // Beats are registered out, adding the one cycle on top of the wait.
          app_rd_data_valid_o <= 1'b1;
          app_rd_data_o       <= rd_lanes;
          app_rd_data_end_o   <= last_beat;
          if (last_beat) begin
            state_r  <= IDLE;
            rd_cnt_o <= rd_cnt_o + 16'd1;
          end else begin
            beat_r <= beat_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule
